// File: rtl/alt_chk_pkg.sv
// alt_chk_pkg: state encodings and default parameters shared by alt_stream_checker
package alt_chk_pkg;
    typedef enum logic [1:0] {ST_EMPTY, ST_PH_A, ST_PH_NB, ST_PH_B} state_t;
    localparam int DEF_WIDTH = 1;
    localparam int DEF_RUN = 1;
    localparam int DEF_MIN_PHASES = 3;
    localparam int DEF_CNT_W = 8;
    localparam int DEF_ERR_W = 8;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: counter that sticks at all-ones; clr with inc loads 1
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (rst) q <= '0;
        else if (clr) q <= W'(inc);
        else if (inc && q != '1) q <= q + W'(1);
    end
endmodule

// File: rtl/alt_stream_checker.sv
// alt_stream_checker: checks A^RUN B^RUN alternation of learned symbols; ALTCHK_ERR_CNT_EN adds err_cnt
module alt_stream_checker
    import alt_chk_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int RUN        = DEF_RUN,
    parameter int MIN_PHASES = DEF_MIN_PHASES,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int ERR_W      = DEF_ERR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             check,
    output logic             error,
    output logic [CNT_W-1:0] phase_cnt
`ifdef ALTCHK_ERR_CNT_EN
    ,
    output logic [ERR_W-1:0] err_cnt
`endif
);
    localparam int RW = $clog2(RUN + 1);
    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b;
    logic             r_bk, r_error;
    logic [RW-1:0]    r_run, w_run;
    logic             w_hit, w_new_b, w_last, w_viol, w_start, w_done;
    assign w_hit   = (r_state == ST_PH_A && in_data == r_a) || (r_state == ST_PH_B && in_data == r_b);
    assign w_new_b = r_state == ST_PH_NB && in_data != r_a;
    assign w_last  = r_run + RW'(1) == RW'(RUN);
    assign w_viol  = in_valid && r_state != ST_EMPTY && !w_hit && !w_new_b;
    assign w_start = in_valid && (r_state == ST_EMPTY || w_viol);
    assign w_done  = in_valid && ((w_hit && w_last) || (w_new_b && RUN == 1));
    always_comb begin
        w_next = r_state;
        w_run  = r_run;
        if (w_start) begin
            w_next = RUN == 1 ? ST_PH_NB : ST_PH_A;
            w_run  = RW'(1);
        end else if (w_done) begin
            w_next = r_state == ST_PH_A ? (r_bk ? ST_PH_B : ST_PH_NB) : ST_PH_A;
            w_run  = '0;
        end else if (in_valid) begin
            w_next = w_new_b ? ST_PH_B : r_state;
            w_run  = w_new_b ? RW'(1) : r_run + RW'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_a     <= '0;
            r_b     <= '0;
            r_bk    <= 1'b0;
            r_run   <= '0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_next;
            r_run   <= w_run;
            r_error <= w_viol;
            if (w_start) begin
                r_a  <= in_data;
                r_bk <= 1'b0;
            end else if (in_valid && w_new_b) begin
                r_b  <= in_data;
                r_bk <= 1'b1;
            end
        end
    end
    sat_counter #(.W(CNT_W)) u_phase (
        .clk(clk),
        .rst(rst),
        .clr(w_start),
        .inc(w_done || (w_start && RUN == 1)),
        .q  (phase_cnt)
    );
`ifdef ALTCHK_ERR_CNT_EN
    sat_counter #(.W(ERR_W)) u_err (
        .clk(clk),
        .rst(rst),
        .clr(1'b0),
        .inc(w_viol),
        .q  (err_cnt)
    );
`endif
    assign check = phase_cnt >= CNT_W'(MIN_PHASES);
    assign error = r_error;
endmodule

// File: tb/tb_alt_stream_checker.sv
// tb_alt_stream_checker: two configurations against a sequence-level reference model
module tb_alt_stream_checker;
    logic       clk = 1'b0;
    logic       rst, v0, v1;
    logic [0:0] d0;
    logic [3:0] d1;
    logic       chk0, chk1, err0, err1;
    logic [7:0] ph0, ph1;
`ifdef ALTCHK_ERR_CNT_EN
    logic [7:0] ec0, ec1;
`endif
    int n_chk = 0, n_err = 0;
    int m_n[2], m_a[2], m_b[2], m_e[2], m_ec[2];
    always #5 clk = ~clk;
    alt_stream_checker #(.WIDTH(1), .RUN(1), .MIN_PHASES(3)) u0 (
        .clk(clk), .rst(rst), .in_valid(v0), .in_data(d0),
        .check(chk0), .error(err0), .phase_cnt(ph0)
`ifdef ALTCHK_ERR_CNT_EN
        , .err_cnt(ec0)
`endif
    );
    alt_stream_checker #(.WIDTH(4), .RUN(2), .MIN_PHASES(3)) u1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_data(d1),
        .check(chk1), .error(err1), .phase_cnt(ph1)
`ifdef ALTCHK_ERR_CNT_EN
        , .err_cnt(ec1)
`endif
    );
    task automatic check_eq(string tag, int got, int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic int run_of(int i);
        return i == 0 ? 1 : 2;
    endfunction
    // Symbol k of the current run lies in phase k/RUN; even phases repeat A, odd phases repeat B != A.
    function automatic bit fits(int i, int x);
        int r = run_of(i);
        int p = m_n[i] / r;
        if (p % 2 == 0) return x == m_a[i];
        if (p == 1 && m_n[i] % r == 0) return x != m_a[i];
        return x == m_b[i];
    endfunction
    function automatic int phases(int i);
        int p = m_n[i] / run_of(i);
        return p > 255 ? 255 : p;
    endfunction
    task automatic model(int i, bit r, bit v, int x);
        if (r) begin
            m_n[i] = 0; m_e[i] = 0; m_ec[i] = 0;
        end else if (!v) begin
            m_e[i] = 0;
        end else if (m_n[i] == 0 || !fits(i, x)) begin
            m_e[i] = m_n[i] != 0;
            if (m_n[i] != 0 && m_ec[i] < 255) m_ec[i]++;
            m_a[i] = x;
            m_n[i] = 1;
        end else begin
            if (m_n[i] == run_of(i)) m_b[i] = x;
            m_n[i]++;
            m_e[i] = 0;
        end
    endtask
    task automatic compare();
        check_eq("phase0", int'(ph0), phases(0));
        check_eq("check0", int'(chk0), int'(phases(0) >= 3));
        check_eq("error0", int'(err0), m_e[0]);
        check_eq("phase1", int'(ph1), phases(1));
        check_eq("check1", int'(chk1), int'(phases(1) >= 3));
        check_eq("error1", int'(err1), m_e[1]);
`ifdef ALTCHK_ERR_CNT_EN
        check_eq("errcnt0", int'(ec0), m_ec[0]);
        check_eq("errcnt1", int'(ec1), m_ec[1]);
`endif
    endtask
    task automatic cycle(bit r, bit va, int xa, bit vb, int xb);
        rst = r; v0 = va; d0 = xa[0]; v1 = vb; d1 = xb[3:0];
        @(posedge clk);
        model(0, r, va, xa & 1);
        model(1, r, vb, xb & 15);
        @(negedge clk);
        compare();
    endtask
    function automatic int want(int i);
        int r = run_of(i);
        int p = m_n[i] / r;
        int m = i == 0 ? 2 : 16;
        if (m_n[i] == 0 || $urandom % 8 == 0) return int'($urandom % m);
        if (p % 2 == 0) return m_a[i];
        if (p == 1 && m_n[i] % r == 0) return (m_a[i] + 1 + int'($urandom % (m - 1))) % m;
        return m_b[i];
    endfunction
    int s0[5] = '{0, 1, 0, 0, 1};
    int s1[8] = '{5, 5, 10, 10, 5, 5, 5, 10};
    initial begin
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++) cycle(0, k < 5, k < 5 ? s0[k] : 0, 1, s1[k]);
        cycle(1, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) cycle(0, 1, 1, 1, 5);
        cycle(1, 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            cycle(0, 1, k % 2, 1, s1[k]);
            repeat (4) cycle(0, 0, 0, 0, 0);
        end
        cycle(0, 1, 0, 1, 5);
        cycle(1, 1, 3, 1, 3);
        cycle(0, 0, 0, 0, 0);
        for (int k = 0; k < 300; k++) cycle(0, 1, k % 2, k % 3 == 0, 7);
        for (int k = 0; k < 4; k++) cycle(0, 1, 1, 1, k % 2 == 0 ? 5 : 6);
        cycle(1, 0, 0, 0, 0);
        for (int k = 0; k < 800; k++) begin
            automatic int xa = want(0);
            automatic int xb = want(1);
            cycle($urandom % 250 == 0, $urandom % 4 != 0, xa, $urandom % 4 != 0, xb);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
